// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: walks two WIDTH-bit operands two bits per
// cycle from the MSB slice down and stops at the first differing slice.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             a_gt_b
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [IDX_W-1:0] idx;

    logic [WIDTH-1:0] ra_sh;
    logic [WIDTH-1:0] rb_sh;
    logic [1:0]       sa;
    logic [1:0]       sb;
    logic             eq_s;
    logic             lt_s;
    logic             gt_s;

    // Select the current slice by shifting it down to bit 0.
    always_comb begin
        ra_sh = ra >> {idx, 1'b0};
        rb_sh = rb >> {idx, 1'b0};
        sa    = ra_sh[1:0];
        sb    = rb_sh[1:0];
        eq_s  = (sa == sb);
        lt_s  = (~sa[1] & sb[1]) | ((sa[1] ~^ sb[1]) & ~sa[0] & sb[0]);
        gt_s  = (sa[1] & ~sb[1]) | ((sa[1] ~^ sb[1]) & sa[0] & ~sb[0]);
    end

    // Handshake: start is accepted only in IDLE (a/b captured on that edge);
    // busy is high while RUN; done is a one-cycle pulse in DONE with the flags
    // freshly valid. start seen in RUN or DONE is dropped, never queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            a_eq_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_gt_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra     <= a;
                        rb     <= b;
                        idx    <= IDX_TOP;
                        a_eq_b <= 1'b0;
                        a_lt_b <= 1'b0;
                        a_gt_b <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (lt_s) begin
                        a_lt_b <= 1'b1;
                        state  <= DONE;
                    end else if (gt_s) begin
                        a_gt_b <= 1'b1;
                        state  <= DONE;
                    end else if (idx == '0) begin
                        a_eq_b <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: vector table plus hand-written
// sequences for reset abort, ignored inputs and back-to-back operation.
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_gt_b;

    int checks = 0;
    int errors = 0;

    // Expected {busy, done, a_eq_b, a_lt_b, a_gt_b} per sampled cycle.
    logic [4:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        int               m;
        logic [2:0]       flags;   // {eq, lt, gt}
        string            name;
    } vec_t;

    vec_t vecs[11];

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b),
        .a_gt_b (a_gt_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] out_vec();
        return {busy, done, a_eq_b, a_lt_b, a_gt_b};
    endfunction

    // Scoreboard: pops the expected entry and compares against the outputs.
    task automatic check_cycle(input string name);
        logic [4:0] exp;
        logic [4:0] act;
        exp = exp_q.pop_front();
        act = out_vec();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {busy,done,eq,lt,gt}=%05b expected %05b at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Driver: one compare from IDLE, then hold_cycles of idle observation.
    task automatic run_compare(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input int m, input logic [2:0] flags,
                               input int hold_cycles, input string name);
        a     = va;
        b     = vb;
        start = 1'b1;
        for (int k = 0; k <= m + 1 + hold_cycles; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                a     = WIDTH'($urandom_range(0, 255));
                b     = WIDTH'($urandom_range(0, 255));
            end
            if (k < m)       exp_q.push_back(5'b10000);
            else if (k == m) exp_q.push_back({2'b01, flags});
            else             exp_q.push_back({2'b00, flags});
            check_cycle(name);
        end
    endtask

    initial begin
        vecs[0]  = '{8'hA5, 8'hA5, 4, 3'b100, "eq_a5"};
        vecs[1]  = '{8'h40, 8'h80, 1, 3'b010, "msb_lt"};
        vecs[2]  = '{8'h0E, 8'h0D, 4, 3'b001, "lsb_gt"};
        vecs[3]  = '{8'h24, 8'h34, 2, 3'b010, "mid_lt"};
        vecs[4]  = '{8'hFF, 8'h00, 1, 3'b001, "max_vs_zero"};
        vecs[5]  = '{8'h00, 8'h00, 4, 3'b100, "eq_zero"};
        vecs[6]  = '{8'h01, 8'h02, 4, 3'b010, "lsb_lt"};
        vecs[7]  = '{8'hC3, 8'hC7, 3, 3'b010, "slice1_lt"};
        vecs[8]  = '{8'h7B, 8'h6B, 2, 3'b001, "slice2_gt"};
        vecs[9]  = '{8'hFF, 8'hFF, 4, 3'b100, "eq_max"};
        vecs[10] = '{8'h80, 8'h7F, 1, 3'b001, "msb_gt"};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        exp_q.push_back(5'b00000);
        check_cycle("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(5'b00000);
        check_cycle("post_reset_idle");

        // Reset mid-run aborts the compare asynchronously.
        a     = 8'hA5;
        b     = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(5'b10000);
        check_cycle("abort_busy_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(5'b00000);
        check_cycle("abort_async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_q.push_back(5'b00000);
            check_cycle("abort_no_done");
        end

        // Table of single compares.
        for (int i = 0; i < 11; i++) begin
            run_compare(vecs[i].va, vecs[i].vb, vecs[i].m, vecs[i].flags, 3, vecs[i].name);
        end

        // Mid slice with a changed and start pulsed during busy.
        a     = 8'h24;
        b     = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(5'b10000);
        check_cycle("ignore_e0_busy");
        a     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        exp_q.push_back(5'b10000);
        check_cycle("ignore_e1_busy");
        start = 1'b0;
        @(negedge clk);
        exp_q.push_back(5'b01010);
        check_cycle("ignore_e2_done_lt");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_q.push_back(5'b00010);
            check_cycle("ignore_no_restart");
        end

        // Back-to-back with start held high: accepts at edges 0, 3, 6.
        a     = 8'h40;
        b     = 8'h80;
        start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 3 == 0)      exp_q.push_back(5'b10000);
            else if (k % 3 == 1) exp_q.push_back(5'b01010);
            else                 exp_q.push_back(5'b00010);
            check_cycle("b2b_held_start");
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_q.push_back(5'b00010);
            check_cycle("b2b_idle_after");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Compares two WIDTH-bit unsigned operands 2 bits per cycle, MSB slice first, and produces a one-hot equal/less/greater result. It stops early at the first differing slice. The block sits directly downstream of the team's 2-bit slice compare logic: it extends that eq/lt/gt slice decision to wide operands through a start/busy/done handshake. It feeds any consumer that needs a registered magnitude verdict.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥2. NSLICE = WIDTH/2.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a compare. Sampled only in IDLE.
- a  input  WIDTH  operand A, unsigned. Sampled only on the accepting edge.
- b  input  WIDTH  operand B, unsigned. Sampled only on the accepting edge.
- busy  output  1  high while a compare is in progress (RUN state).
- done  output  1  one-cycle pulse: result valid and newly updated.
- a_eq_b  output  1  result flag: A == B.
- a_lt_b  output  1  result flag: A < B.
- a_gt_b  output  1  result flag: A > B.

## Operation
- **Registered state:**
  - FSM state: IDLE, RUN or DONE.
  - Latched operands ra and rb.
  - Slice index idx, width clog2(NSLICE), minimum 1.
  - Output flags.
- **Slice compare:** slice i of X is {X[2i+1], X[2i]}.
  - eq_s = (ra_i == rb_i).
  - lt_s = (ra_i < rb_i), computed as (~ra[2i+1] & rb[2i+1]) | ((ra[2i+1] ~^ rb[2i+1]) & ~ra[2i] & rb[2i]).
  - gt_s is symmetric to lt_s.
- **IDLE:**
  - With start=1 at an edge: ra←a, rb←b, idx←NSLICE-1, all three flags←0, state→RUN.
  - With start=0: hold. Flags keep the previous result.
- **RUN:** each edge evaluates slice idx.
  - lt_s: a_lt_b←1, state→DONE.
  - gt_s: a_gt_b←1, state→DONE.
  - eq_s and idx==0: a_eq_b←1, state→DONE.
  - eq_s and idx>0: idx←idx-1, stay in RUN.
- **DONE:** lasts exactly one cycle, then →IDLE. start is ignored in DONE.
- **Output decode:**
  - busy = (state==RUN).
  - done = (state==DONE).
  - Both are decoded from registered state; no combinational path from inputs to outputs.
- **Flag rules:**
  - At most one flag is high at any time.
  - Exactly one flag is high from the DONE cycle until the next accepted start.
  - All flags are 0 while busy.
- **Ignored inputs:**
  - start asserted during RUN or DONE has no effect and is not queued.
  - Changes on a or b after the accepting edge have no effect.

## Timing
- **Reset:** rst_n low forces, asynchronously:
  - state=IDLE, idx=0, ra=rb=0;
  - busy=0, done=0, a_eq_b=a_lt_b=a_gt_b=0.
  - A reset in mid-operation aborts the compare; no done pulse follows.
- **Release:** first accept is possible on the first rising edge with rst_n=1 and start=1.
- **Latency:** the accepting edge is edge 0. Let m be the position of the first differing slice counted from the MSB, 1..NSLICE, with m=NSLICE when the operands are equal.
  - busy is high for m cycles, after edges 0..m-1.
  - done and the flags become valid after edge m.
  - done falls after edge m+1.
- **Throughput:** with start held high, the next accept happens at edge m+2, when the FSM is back in IDLE. Minimum period is 3 cycles at m=1; worst case is NSLICE+2.
- **Boundary case WIDTH=2:** m=1 always.

## Test plan
- Reset mid-run: WIDTH=8, a=8'hA5, b=8'hA5, start; drop rst_n during busy.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: after release, no done pulse appears without a new start.
- Equal operands: a=8'hA5, b=8'hA5, single start pulse.
  - Required: busy high for 4 cycles.
  - Required: done pulses after edge 4, with a_eq_b=1 and the other flags 0.
  - Required: flags hold until the next start.
- MSB early exit: a=8'h40, b=8'h80 (slices 01 vs 10).
  - Required: done after edge 1 with a_lt_b=1.
  - Required: busy high for exactly 1 cycle.
- LSB decision: a=8'h0E, b=8'h0D (first three slices equal, last slice 10 vs 01).
  - Required: done after edge 4 with a_gt_b=1.
- Mid slice, plus ignored inputs: a=8'h24, b=8'h34; during busy, change a to 8'hFF and pulse start.
  - Required: done after edge 2 with a_lt_b=1.
  - Required: no second compare starts.
- Back-to-back with start held high: a=8'h40, b=8'h80 held.
  - Required: accepts at edges 0, 3, 6.
  - Required: done after edges 1, 4, 7.
  - Required: flags read 0 during each busy cycle and a_lt_b=1 in each done cycle.
